// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// Module: instr_fetch
//
// Purpose:
//   Instruction fetch sequencer. This is the producer side of the instruction
//   decoder interface. It owns the program counter and reads one instruction
//   byte at a time from a synchronous program memory. It presents each byte
//   on instruction/EN and holds it until the consumer acks it. It also
//   handles jump redirects, a level-sensitive halt, and PC wrap-around.
//
//   Each instruction passes through three states:
//     FETCH   : issue a read at pc (unless halted or redirected)
//     WAIT    : capture the returning byte, advance pc
//     PRESENT : hold instruction with EN=1 until ack
//   The back-to-back rate is therefore one instruction every three cycles.
//
// Parameters:
//   ADDR_W  program address width; pc wraps modulo 2**ADDR_W
//   DATA_W  instruction width ([7:4] opcode, [3:0] immediate for the decoder)
//   CNT_W   width of the retired-instruction counter
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   mem_addr     out  ADDR_W  program memory read address (equals pc)
//   mem_rd       out  1       read strobe; mem_data is valid one cycle later
//   mem_data     in   DATA_W  program memory read data
//   instruction  out  DATA_W  instruction byte to the decoder, held while EN=1
//   EN           out  1       instruction valid / decoder enable
//   ack          in   1       consumer accepts the instruction (only with EN=1)
//   jump         in   1       redirect request (with ack, or any cycle EN=0)
//   jump_addr    in   ADDR_W  redirect target
//   halt         in   1       level; blocks new fetches while high
//   pc           out  ADDR_W  address of the next byte to fetch
//   retired      out  CNT_W   number of acked instructions, wrapping
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instruction,
    output logic              EN,
    input  logic              ack,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              en_q, en_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // State and datapath registers. Reset has priority over everything, so a
    // read that is in flight when reset hits is simply never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            en_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            en_q      <= en_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and the combinational read strobe.
    // A jump in FETCH wins over both halt and the pending read: the read is
    // suppressed, and the next FETCH cycle issues it at the new pc. A jump in
    // WAIT drops the returning byte and does not apply the +1 increment.
    // In PRESENT a jump only takes effect together with ack.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        en_d      = en_q;
        retired_d = retired_q;
        mem_rd    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (jump) begin
                    pc_d = jump_addr;
                end else if (!halt && !rst) begin
                    mem_rd  = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (jump) begin
                    pc_d    = jump_addr;
                    state_d = S_FETCH;
                end else begin
                    instr_d = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    en_d    = 1'b1;
                    state_d = S_PRESENT;
                end
            end

            S_PRESENT: begin
                if (ack) begin
                    retired_d = retired_q + CNT_W'(1);
                    en_d      = 1'b0;
                    state_d   = S_FETCH;
                    if (jump) begin
                        pc_d = jump_addr;
                    end
                end
            end

            default: begin
                en_d    = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

    // The read address always tracks pc. It only matters while mem_rd=1.
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign EN          = en_q;
    assign retired     = retired_q;

endmodule
